clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Parametrised bank of independent programmable clock dividers running off the 100 MHz system clock. It replaces the single hard-wired 1 kHz divider in the top level and supplies divided square waves plus single-cycle rise/fall ticks to the processor, servo PWM and audio logic. Each channel's half-period is reprogrammable at run time, and a new value takes effect only at a period boundary, so no output ever glitches.

## Interface
- `NUM_CH`, 4: number of divider channels (1..16).
- `CNT_W`, 32: counter and half-period width in bits.
- `DEFAULT_HALF`, 50000: half-period in clock cycles loaded at reset. The default gives 1 kHz from 100 MHz.
- `clock` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cfg_we` in 1: configuration write strobe.
- `cfg_ch` in max(1,$clog2(NUM_CH)): target channel for the write.
- `cfg_half` in CNT_W: new half-period in clock cycles.
- `ch_en` in NUM_CH: per-channel run enable.
- `sync_clr` in 1: restarts all channels phase-aligned.
- `clk_out` out NUM_CH: divided square wave, registered.
- `tick_rise` out NUM_CH: 1-cycle pulse in the cycle `clk_out` goes high.
- `tick_fall` out NUM_CH: 1-cycle pulse in the cycle `clk_out` goes low.
- `pending` out NUM_CH: a written half-period is waiting for the next wrap.

## Operation
- Each channel has the following registers:
  - counter `cnt`, CNT_W bits
  - active limit `lim`
  - shadow `shd`
  - flag `pend`, driven out as `pending`
  - output register `clk_out`
- Reset values: `cnt`=0, `clk_out`=0, `tick_*`=0, `lim`=`shd`=DEFAULT_HALF, `pend`=0.
- Effective limit L = max(`lim`,1). A half-period of 0 behaves as 1, giving an output of `clock`/2.
- Running channel (`ch_en`=1, no `sync_clr`):
  - If `cnt` ≥ L−1, this is a wrap:
    - `cnt`←0 and `clk_out` toggles.
    - The matching tick pulses for one cycle.
    - If `pend`=1, then `lim`←`shd` and `pend`←0.
  - Otherwise `cnt`←`cnt`+1.
  - The comparison is ≥ so that a shrunken limit cannot cause wrap-around past 2^CNT_W.
- Disabled channel (`ch_en`=0):
  - `cnt`←0, `clk_out`←0, no ticks.
  - A pending value is applied immediately: `lim`←`shd`, `pend`←0.
  - If `clk_out` was high, `tick_fall` pulses once in the cycle it drops.
- `sync_clr`=1: every channel behaves as disabled for that cycle, including pending apply and the falling tick if needed. `sync_clr` has priority over `ch_en`.
- Config write: when `cfg_we`=1 and `cfg_ch`<NUM_CH, then `shd[cfg_ch]`←`cfg_half` and `pend`←1. A write with `cfg_ch`≥NUM_CH is ignored.
- Write coincident with a wrap on the same channel:
  - The wrap uses the old `shd` if `pend` was set.
  - The new value lands in `shd` with `pend`=1 and applies at the following wrap.
  - A write always takes effect at the first wrap strictly after the write cycle.
- Back-to-back writes before a wrap: the last write wins.
- Channels are fully independent apart from the shared config port and `sync_clr`.

## Timing
- Enable to first rising edge: L cycles. With `ch_en` rising before edge 0, `clk_out` is high after edge L−1, i.e. visible L cycles later.
- Period 2L cycles, duty exactly 50%.
- Ticks are registered together with `clk_out`: `tick_rise` is high in exactly the first high cycle of `clk_out`.
- Config latency: a write in cycle t affects the first half-period starting after the first wrap at or after t+1.
- `pending` is asserted the cycle after the write and deasserted the cycle after the applying wrap.
- Async reset mid-period: all outputs return to their reset values immediately, with no tick emitted. Counting resumes on the first edge after deassertion.
- No combinational path from inputs to outputs.

## Structure
- Package `clk_div_pkg` holds:
  - SYSTEM_FREQ = 100_000_000
  - constant function `half_period(freq)` = SYSTEM_FREQ/freq/2
  - DEFAULT_HALF derived via `half_period(1000)`
- Sub-module `clk_div_chan` implements one channel (counter, limit, shadow, output, ticks).
- `clk_div_bank` decodes `cfg_ch` into per-channel write strobes and generates NUM_CH instances.

## Test plan
- Reset, `ch_en`=1, DEFAULT_HALF=4 → `clk_out` toggles every 4 cycles, period 8. `tick_rise` fires once per period, aligned to the rising edge.
- Running with half=4, write `cfg_half`=2 mid-period → current half-period completes at 4, following half-periods are 2, `pending` high in between.
- `cfg_half`=0 on channel 1 → channel 1 toggles every cycle. Other channels are undisturbed.
- Write coincident with a wrap, then a second write before the next wrap → first value never applied, second value applied at the next wrap.
- `sync_clr` pulse with channels at different phases → all `clk_out` low, `tick_fall` on the channels that were high. After that, channels with equal half-periods stay in phase.
- Async reset asserted mid-period with a pending write → immediate return to reset values, `pending`=0, DEFAULT_HALF restored. Write to `cfg_ch`=NUM_CH (non-power-of-2 NUM_CH) → no effect.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and types for the clock divider bank.
// Half-periods are expressed in system clock cycles.
package clk_div_pkg;

    localparam int unsigned SYSTEM_FREQ = 100_000_000;

    function automatic int unsigned half_period(input int unsigned freq);
        return SYSTEM_FREQ / freq / 2;
    endfunction

    localparam int unsigned DEFAULT_HALF = half_period(1000);

    // What a channel does in a given cycle.
    typedef enum logic [1:0] {
        CH_RUN  = 2'd0,
        CH_WRAP = 2'd1,
        CH_IDLE = 2'd2
    } chan_op_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active limit, shadow limit, output register
// and rise/fall ticks, all updated together on the system clock.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int          CNT_W        = 32,
    parameter int unsigned DEFAULT_HALF = clk_div_pkg::DEFAULT_HALF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] half_i,
    output logic             clk_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             pend_o
);

    localparam logic [CNT_W-1:0] DEF_LIM = CNT_W'(DEFAULT_HALF);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lim_q, lim_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] last_cnt;
    chan_op_e         op;

    // A programmed half-period of 0 is treated as 1, so the last count is 0.
    assign last_cnt = (lim_q == '0) ? '0 : lim_q - 1'b1;

    always_comb begin
        if (clr_i || !en_i) begin
            op = CH_IDLE;
        end else if (cnt_q >= last_cnt) begin
            op = CH_WRAP;
        end else begin
            op = CH_RUN;
        end
    end

    // NOTE: every next-state signal gets a default first so no latch is inferred.
    always_comb begin
        cnt_d  = cnt_q;
        lim_d  = lim_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        clk_d  = clk_q;
        rise_d = 1'b0;
        fall_d = 1'b0;

        unique case (op)
            CH_IDLE: begin
                cnt_d  = '0;
                clk_d  = 1'b0;
                fall_d = clk_q;
                if (pend_q) begin
                    lim_d  = shd_q;
                    pend_d = 1'b0;
                end
            end
            CH_WRAP: begin
                cnt_d  = '0;
                clk_d  = ~clk_q;
                rise_d = ~clk_q;
                fall_d = clk_q;
                if (pend_q) begin
                    lim_d  = shd_q;
                    pend_d = 1'b0;
                end
            end
            default: begin
                cnt_d = cnt_q + 1'b1;
            end
        endcase

        // Applied after the wrap so a coincident write waits for the next wrap.
        if (wr_i) begin
            shd_d  = half_i;
            pend_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            lim_q  <= DEF_LIM;
            shd_q  <= DEF_LIM;
            pend_q <= 1'b0;
            clk_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lim_q  <= lim_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign clk_o  = clk_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign pend_o = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent programmable clock dividers sharing one
// configuration port and a common phase-align clear.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = 32,
    parameter int unsigned DEFAULT_HALF = clk_div_pkg::DEFAULT_HALF,
    localparam int         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_clr,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick_rise,
    output logic [NUM_CH-1:0] tick_fall,
    output logic [NUM_CH-1:0] pending
);

    logic              cfg_ok;
    logic [NUM_CH-1:0] ch_wr;

    // Writes addressed past the last channel are dropped.
    assign cfg_ok = cfg_we && (32'(cfg_ch) < 32'(NUM_CH));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_wr[i] = cfg_ok && (cfg_ch == CH_W'(i));

        clk_div_chan #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_chan (
            .clock  (clock),
            .reset  (reset),
            .en_i   (ch_en[i]),
            .clr_i  (sync_clr),
            .wr_i   (ch_wr[i]),
            .half_i (cfg_half),
            .clk_o  (clk_out[i]),
            .rise_o (tick_rise[i]),
            .fall_o (tick_fall[i]),
            .pend_o (pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with three channels and a half-period of 4.
// Outputs are sampled 1 ns after each rising edge; inputs change there too.
module tb_clk_div_bank;

    logic        clock;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_half;
    logic [2:0]  ch_en;
    logic        sync_clr;
    logic [2:0]  clk_out;
    logic [2:0]  tick_rise;
    logic [2:0]  tick_fall;
    logic [2:0]  pending;

    int total = 0;
    int bad   = 0;

    clk_div_bank #(
        .NUM_CH       (3),
        .CNT_W        (16),
        .DEFAULT_HALF (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .ch_en     (ch_en),
        .sync_clr  (sync_clr),
        .clk_out   (clk_out),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .pending   (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] c, input logic [2:0] r,
                       input logic [2:0] f, input logic [2:0] p);
        check({tag, " clk_out"},   clk_out,   c);
        check({tag, " tick_rise"}, tick_rise, r);
        check({tag, " tick_fall"}, tick_fall, f);
        check({tag, " pending"},   pending,   p);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [15:0] half);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_half = half;
    endtask

    task automatic wr_off();
        cfg_we   = 1'b0;
        cfg_ch   = 2'd0;
        cfg_half = 16'd0;
    endtask

    initial begin
        reset    = 1'b1;
        cfg_we   = 1'b0;
        cfg_ch   = 2'd0;
        cfg_half = 16'd0;
        ch_en    = 3'b000;
        sync_clr = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset", 3'b000, 3'b000, 3'b000, 3'b000);

        // Default half-period 4: high after the 4th edge, period 8.
        reset = 1'b0;
        ch_en = 3'b111;
        step(); chk("k1",  3'b000, 3'b000, 3'b000, 3'b000);
        step(); chk("k2",  3'b000, 3'b000, 3'b000, 3'b000);
        step(); chk("k3",  3'b000, 3'b000, 3'b000, 3'b000);
        step(); chk("k4",  3'b111, 3'b111, 3'b000, 3'b000);
        step(); chk("k5",  3'b111, 3'b000, 3'b000, 3'b000);
        step(); chk("k6",  3'b111, 3'b000, 3'b000, 3'b000);
        step(); chk("k7",  3'b111, 3'b000, 3'b000, 3'b000);
        step(); chk("k8",  3'b000, 3'b000, 3'b111, 3'b000);
        step(); chk("k9",  3'b000, 3'b000, 3'b000, 3'b000);
        step(); chk("k10", 3'b000, 3'b000, 3'b000, 3'b000);
        step(); chk("k11", 3'b000, 3'b000, 3'b000, 3'b000);
        step(); chk("k12", 3'b111, 3'b111, 3'b000, 3'b000);
        step(); chk("k13", 3'b111, 3'b000, 3'b000, 3'b000);

        // Mid-period write of 2 to ch0: applies at the wrap on edge 16.
        wr(2'd0, 16'd2);
        step(); chk("k14", 3'b111, 3'b000, 3'b000, 3'b001);
        wr_off();
        step(); chk("k15", 3'b111, 3'b000, 3'b000, 3'b001);
        step(); chk("k16", 3'b000, 3'b000, 3'b111, 3'b000);
        step(); chk("k17", 3'b000, 3'b000, 3'b000, 3'b000);
        step(); chk("k18", 3'b001, 3'b001, 3'b000, 3'b000);
        step(); chk("k19", 3'b001, 3'b000, 3'b000, 3'b000);
        step(); chk("k20", 3'b110, 3'b110, 3'b001, 3'b000);
        step(); chk("k21", 3'b110, 3'b000, 3'b000, 3'b000);
        step(); chk("k22", 3'b111, 3'b001, 3'b000, 3'b000);
        step(); chk("k23", 3'b111, 3'b000, 3'b000, 3'b000);
        step(); chk("k24", 3'b000, 3'b000, 3'b111, 3'b000);

        // Half-period 0 on ch1: toggles every cycle after its edge-28 wrap.
        wr(2'd1, 16'd0);
        step(); chk("k25", 3'b000, 3'b000, 3'b000, 3'b010);
        wr_off();
        step(); chk("k26", 3'b001, 3'b001, 3'b000, 3'b010);
        step(); chk("k27", 3'b001, 3'b000, 3'b000, 3'b010);
        step(); chk("k28", 3'b110, 3'b110, 3'b001, 3'b000);
        step(); chk("k29", 3'b100, 3'b000, 3'b010, 3'b000);
        step(); chk("k30", 3'b111, 3'b011, 3'b000, 3'b000);
        step(); chk("k31", 3'b101, 3'b000, 3'b010, 3'b000);
        step(); chk("k32", 3'b010, 3'b010, 3'b101, 3'b000);
        step(); chk("k33", 3'b000, 3'b000, 3'b010, 3'b000);
        step(); chk("k34", 3'b011, 3'b011, 3'b000, 3'b000);
        step(); chk("k35", 3'b001, 3'b000, 3'b010, 3'b000);

        // ch2: write 6 coincident with the edge-36 wrap, then 3 before edge 40.
        wr(2'd2, 16'd6);
        step(); chk("k36", 3'b110, 3'b110, 3'b001, 3'b100);
        wr_off();
        step(); chk("k37", 3'b100, 3'b000, 3'b010, 3'b100);
        wr(2'd2, 16'd3);
        step(); chk("k38", 3'b111, 3'b011, 3'b000, 3'b100);
        wr_off();
        step(); chk("k39", 3'b101, 3'b000, 3'b010, 3'b100);
        step(); chk("k40", 3'b010, 3'b010, 3'b101, 3'b000);
        step(); chk("k41", 3'b000, 3'b000, 3'b010, 3'b000);
        step(); chk("k42", 3'b011, 3'b011, 3'b000, 3'b000);
        step(); chk("k43", 3'b101, 3'b100, 3'b010, 3'b000);
        step(); chk("k44", 3'b110, 3'b010, 3'b001, 3'b000);
        step(); chk("k45", 3'b100, 3'b000, 3'b010, 3'b000);
        step(); chk("k46", 3'b011, 3'b011, 3'b100, 3'b000);

        // ch1 gets 3 (pending), then sync_clr applies it and realigns phases.
        wr(2'd1, 16'd3);
        step(); chk("k47", 3'b001, 3'b000, 3'b010, 3'b010);
        wr_off();
        sync_clr = 1'b1;
        step(); chk("k48", 3'b000, 3'b000, 3'b001, 3'b000);
        sync_clr = 1'b0;
        step(); chk("k49", 3'b000, 3'b000, 3'b000, 3'b000);
        step(); chk("k50", 3'b001, 3'b001, 3'b000, 3'b000);
        step(); chk("k51", 3'b111, 3'b110, 3'b000, 3'b000);
        step(); chk("k52", 3'b110, 3'b000, 3'b001, 3'b000);
        step(); chk("k53", 3'b110, 3'b000, 3'b000, 3'b000);
        step(); chk("k54", 3'b001, 3'b001, 3'b110, 3'b000);
        step(); chk("k55", 3'b001, 3'b000, 3'b000, 3'b000);
        step(); chk("k56", 3'b000, 3'b000, 3'b001, 3'b000);
        step(); chk("k57", 3'b110, 3'b110, 3'b000, 3'b000);

        // Pending write on ch2, then async reset in the middle of the cycle.
        wr(2'd2, 16'd7);
        step(); chk("k58", 3'b111, 3'b001, 3'b000, 3'b100);
        wr_off();
        #2;
        reset = 1'b1;
        #1;
        chk("async reset", 3'b000, 3'b000, 3'b000, 3'b000);
        repeat (2) @(posedge clock);
        #1;
        chk("reset held", 3'b000, 3'b000, 3'b000, 3'b000);

        // After release all channels run at the default; cfg_ch=3 is out of range.
        reset = 1'b0;
        wr(2'd3, 16'd1);
        step(); chk("r1",  3'b000, 3'b000, 3'b000, 3'b000);
        wr_off();
        step(); chk("r2",  3'b000, 3'b000, 3'b000, 3'b000);
        step(); chk("r3",  3'b000, 3'b000, 3'b000, 3'b000);
        step(); chk("r4",  3'b111, 3'b111, 3'b000, 3'b000);
        step(); chk("r5",  3'b111, 3'b000, 3'b000, 3'b000);
        step(); chk("r6",  3'b111, 3'b000, 3'b000, 3'b000);
        step(); chk("r7",  3'b111, 3'b000, 3'b000, 3'b000);
        step(); chk("r8",  3'b000, 3'b000, 3'b111, 3'b000);
        step(); chk("r9",  3'b000, 3'b000, 3'b000, 3'b000);
        step(); chk("r10", 3'b000, 3'b000, 3'b000, 3'b000);
        step(); chk("r11", 3'b000, 3'b000, 3'b000, 3'b000);
        step(); chk("r12", 3'b111, 3'b111, 3'b000, 3'b000);

        // Disabling a high channel drops it with a single falling tick.
        ch_en = 3'b101;
        step(); chk("r13", 3'b101, 3'b000, 3'b010, 3'b000);
        step(); chk("r14", 3'b101, 3'b000, 3'b000, 3'b000);
        step(); chk("r15", 3'b101, 3'b000, 3'b000, 3'b000);
        step(); chk("r16", 3'b000, 3'b000, 3'b101, 3'b000);
        step(); chk("r17", 3'b000, 3'b000, 3'b000, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
